// File: rtl/silent_pkg.sv
// Shared types and constants for the silent_scheduler filter-pass launcher.
package silent_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } state_e;

    // Cycles a pass needs beyond one per transducer.
    localparam int unsigned BUSY_MARGIN = 8;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/silent_scheduler_sync_divider.sv
// Sync prescaler: passes one SYNC in every DIV+1 as a TICK, starting with the first.
module sync_divider
    import silent_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 SYNC,
    input  logic [DIV_WIDTH-1:0] DIV,
    output logic                 TICK
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        TICK  = 1'b0;
        if (SYNC) begin
            if (cnt_q == '0) begin
                TICK  = 1'b1;
                cnt_d = DIV;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/silent_scheduler.sv
// Launches filter passes on prescaled SYNC ticks, tracks overruns and applies
// a shadowed step/enable configuration atomically at each pass start.
module silent_scheduler
    import silent_pkg::*;
#(
    parameter int unsigned WIDTH       = 13,
    parameter int unsigned DEPTH       = 249,
    parameter int unsigned BUSY_CYCLES = DEPTH + BUSY_MARGIN,
    parameter int unsigned DIV_WIDTH   = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 SYNC,
    input  logic [DIV_WIDTH-1:0] DIV,
    input  logic                 CFG_VALID,
    output logic                 CFG_READY,
    input  logic [WIDTH-1:0]     CFG_STEP,
    input  logic                 CFG_ENABLE,
    output logic                 START,
    output logic [WIDTH-1:0]     STEP,
    output logic                 ENABLE,
    output logic                 BUSY,
    output logic [7:0]           OVERRUN_CNT
);

    localparam int unsigned    BCW       = $clog2(BUSY_CYCLES + 1);
    localparam logic [BCW-1:0] BUSY_LOAD = BCW'(BUSY_CYCLES - 1);

    logic             tick;
    logic             launch;
    state_e           state_q, state_d;
    logic [BCW-1:0]   busy_cnt_q, busy_cnt_d;
    logic             pending_q, pending_d;
    logic [7:0]       overrun_q, overrun_d;
    logic             shadow_full_q, shadow_full_d;
    logic [WIDTH-1:0] shadow_step_q, shadow_step_d;
    logic             shadow_en_q, shadow_en_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic             enable_q, enable_d;

    sync_divider #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_sync_divider (
        .CLK  (CLK),
        .RST  (RST),
        .SYNC (SYNC),
        .DIV  (DIV),
        .TICK (tick)
    );

    always_comb begin
        state_d       = state_q;
        busy_cnt_d    = busy_cnt_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        shadow_full_d = shadow_full_q;
        shadow_step_d = shadow_step_q;
        shadow_en_d   = shadow_en_q;
        step_d        = step_q;
        enable_d      = enable_q;
        launch        = 1'b0;

        // The busy count is loaded as LAUNCH is entered and runs through LAUNCH
        // and RUN, so BUSY spans exactly BUSY_CYCLES cycles including START.
        unique case (state_q)
            IDLE: begin
                if (tick || pending_q) begin
                    launch     = 1'b1;
                    state_d    = LAUNCH;
                    pending_d  = 1'b0;
                    busy_cnt_d = BUSY_LOAD;
                end
            end
            LAUNCH: begin
                state_d = RUN;
                if (busy_cnt_q != '0) begin
                    busy_cnt_d = busy_cnt_q - 1'b1;
                end
            end
            RUN: begin
                if (busy_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    busy_cnt_d = busy_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (tick && (state_q != IDLE)) begin
            pending_d = 1'b1;
            overrun_d = sat_inc8(overrun_q);
        end

        // A zero step would stall the filter, so it is promoted to 1 on capture.
        if (launch && shadow_full_q) begin
            step_d        = shadow_step_q;
            enable_d      = shadow_en_q;
            shadow_full_d = 1'b0;
        end else if (CFG_VALID && !shadow_full_q) begin
            shadow_step_d = (CFG_STEP == '0) ? WIDTH'(1) : CFG_STEP;
            shadow_en_d   = CFG_ENABLE;
            shadow_full_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            busy_cnt_q    <= '0;
            pending_q     <= 1'b0;
            overrun_q     <= '0;
            shadow_full_q <= 1'b0;
            shadow_step_q <= WIDTH'(1);
            shadow_en_q   <= 1'b0;
            step_q        <= WIDTH'(1);
            enable_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_cnt_q    <= busy_cnt_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            shadow_full_q <= shadow_full_d;
            shadow_step_q <= shadow_step_d;
            shadow_en_q   <= shadow_en_d;
            step_q        <= step_d;
            enable_q      <= enable_d;
        end
    end

    assign START       = (state_q == LAUNCH);
    assign BUSY        = (state_q != IDLE);
    assign CFG_READY   = !shadow_full_q;
    assign STEP        = step_q;
    assign ENABLE      = enable_q;
    assign OVERRUN_CNT = overrun_q;

endmodule

// File: tb/tb_silent_scheduler.sv
// Bench for silent_scheduler: scenario table, directed corner sequences and
// random traffic, all checked cycle by cycle against a time-remaining model.
module tb_silent_scheduler;

    localparam int WIDTH       = 13;
    localparam int BUSY_CYCLES = 257;   // 249 transducers + 8 margin

    logic             clk = 1'b0;
    logic             rst, sync, cfg_valid, cfg_ready, cfg_enable;
    logic             start, busy, enable;
    logic [7:0]       div, overrun_cnt;
    logic [WIDTH-1:0] cfg_step, step;

    int n_vec = 0, n_bad = 0, n_starts = 0, cyc = 0;

    // Model: busy_left counts remaining BUSY cycles, skip counts SYNCs to swallow.
    int m_busy_left, m_skip, m_sh_step, m_step, m_ovr;
    bit m_pending, m_full, m_sh_en, m_en, m_start;

    typedef struct {
        int div;
        int period;
        int nsync;
        int cfg_at;
        int cfg_step;
        bit cfg_en;
        int exp_starts;
        int exp_ovr;
        int exp_step;
        bit exp_en;
    } row_t;

    row_t rows[5];

    silent_scheduler #(
        .WIDTH     (WIDTH),
        .DEPTH     (249),
        .DIV_WIDTH (8)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .SYNC        (sync),
        .DIV         (div),
        .CFG_VALID   (cfg_valid),
        .CFG_READY   (cfg_ready),
        .CFG_STEP    (cfg_step),
        .CFG_ENABLE  (cfg_enable),
        .START       (start),
        .STEP        (step),
        .ENABLE      (enable),
        .BUSY        (busy),
        .OVERRUN_CNT (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    task automatic model_reset();
        m_busy_left = 0; m_skip = 0; m_pending = 0; m_ovr = 0;
        m_full = 0; m_sh_step = 1; m_sh_en = 0; m_step = 1; m_en = 0; m_start = 0;
    endtask

    task automatic model_step();
        bit trig, launch;
        if (rst) begin
            model_reset();
            return;
        end
        trig = sync && (m_skip == 0);
        if (sync) m_skip = (m_skip == 0) ? int'(div) : m_skip - 1;
        launch = (m_busy_left == 0) && (trig || m_pending);
        if (m_busy_left > 0 && trig) begin
            m_pending = 1;
            if (m_ovr < 255) m_ovr++;
        end
        if (launch) m_pending = 0;
        if (launch && m_full) begin
            m_step = m_sh_step;
            m_en   = m_sh_en;
            m_full = 0;
        end else if (cfg_valid && !m_full) begin
            m_sh_step = (cfg_step == 0) ? 1 : int'(cfg_step);
            m_sh_en   = cfg_enable;
            m_full    = 1;
        end
        m_busy_left = launch ? BUSY_CYCLES : ((m_busy_left > 0) ? m_busy_left - 1 : 0);
        m_start = launch;
    endtask

    // One clock: sample at negedge, compare, advance model, return just after posedge.
    task automatic cycle();
        logic [24:0] act, want;
        @(negedge clk);
        act  = {start, busy, step, enable, cfg_ready, overrun_cnt};
        want = {m_start, (m_busy_left > 0), WIDTH'(m_step), m_en, !m_full, 8'(m_ovr)};
        check($sformatf("cycle %0d {start,busy,step,en,ready,ovr}", cyc), 32'(act), 32'(want));
        if (start === 1'b1) n_starts++;
        model_step();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; sync = 1'b0; cfg_valid = 1'b0;
        cycle();
        rst = 1'b0;
        n_starts = 0;
    endtask

    task automatic run_row(input int idx, input row_t r);
        apply_reset();
        div = 8'(r.div);
        for (int i = 0; i < r.nsync; i++) begin
            for (int k = 0; k < r.period; k++) begin
                sync       = (k == 0);
                cfg_valid  = (i == 0 && k == r.cfg_at);
                cfg_step   = WIDTH'(r.cfg_step);
                cfg_enable = r.cfg_en;
                cycle();
            end
        end
        sync = 1'b0; cfg_valid = 1'b0;
        repeat (300) cycle();
        check($sformatf("row%0d START count", idx), 32'(n_starts), 32'(r.exp_starts));
        check($sformatf("row%0d OVERRUN_CNT", idx), 32'(overrun_cnt), 32'(r.exp_ovr));
        check($sformatf("row%0d STEP", idx), 32'(step), 32'(r.exp_step));
        check($sformatf("row%0d ENABLE", idx), 32'(enable), 32'(r.exp_en));
        check($sformatf("row%0d CFG_READY", idx), 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; sync = 1'b0; div = '0;
        cfg_valid = 1'b0; cfg_step = '0; cfg_enable = 1'b0;

        //           div per  n  cfg@ step en  starts ovr step en
        rows[0] = '{0, 300, 4, -1,  0, 0,  4, 0, 1, 0};
        rows[1] = '{3, 300, 8, -1,  0, 0,  2, 0, 1, 0};
        rows[2] = '{0, 100, 6, -1,  0, 0,  3, 5, 1, 0};
        rows[3] = '{0, 300, 2, 50,  5, 1,  2, 0, 5, 1};
        rows[4] = '{0, 300, 2, 50,  0, 1,  2, 0, 1, 1};

        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        check("reset START", 32'(start), 32'd0);
        check("reset BUSY", 32'(busy), 32'd0);
        check("reset STEP", 32'(step), 32'd1);
        check("reset ENABLE", 32'(enable), 32'd0);
        check("reset CFG_READY", 32'(cfg_ready), 32'd1);
        check("reset OVERRUN_CNT", 32'(overrun_cnt), 32'd0);

        for (int r = 0; r < 5; r++) run_row(r, rows[r]);

        // Trigger on the final busy cycle is an overrun and relaunches after one idle cycle.
        apply_reset();
        div = '0;
        sync = 1'b1; cycle(); sync = 1'b0;
        repeat (BUSY_CYCLES - 1) cycle();
        check("last-busy BUSY before", 32'(busy), 32'd1);
        sync = 1'b1; cycle(); sync = 1'b0;
        check("last-busy BUSY falls", 32'(busy), 32'd0);
        check("last-busy no START yet", 32'(start), 32'd0);
        cycle();
        check("last-busy pending START", 32'(start), 32'd1);
        repeat (400) cycle();
        check("last-busy START count", 32'(n_starts), 32'd2);
        check("last-busy OVERRUN_CNT", 32'(overrun_cnt), 32'd1);

        // Overrun counter saturation with SYNC held every cycle.
        apply_reset();
        div = '0;
        sync = 1'b1;
        repeat (400) cycle();
        sync = 1'b0;
        check("saturate OVERRUN_CNT", 32'(overrun_cnt), 32'd255);
        repeat (300) cycle();

        // Reset in the middle of a pass abandons it and restores defaults.
        apply_reset();
        div = '0;
        cfg_step = WIDTH'(7); cfg_enable = 1'b1; cfg_valid = 1'b1; cycle(); cfg_valid = 1'b0;
        sync = 1'b1; cycle(); sync = 1'b0;
        repeat (51) cycle();
        check("mid-run STEP", 32'(step), 32'd7);
        check("mid-run BUSY", 32'(busy), 32'd1);
        rst = 1'b1; cycle(); rst = 1'b0;
        check("post-RST BUSY", 32'(busy), 32'd0);
        check("post-RST STEP", 32'(step), 32'd1);
        check("post-RST ENABLE", 32'(enable), 32'd0);
        check("post-RST START", 32'(start), 32'd0);
        n_starts = 0;
        repeat (400) cycle();
        check("post-RST no START", 32'(n_starts), 32'd0);

        // Random traffic against the model.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) div = 8'($urandom_range(0, 3));
            sync       = ($urandom_range(0, 59) == 0);
            cfg_valid  = ($urandom_range(0, 7) == 0);
            cfg_step   = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
            cfg_enable = 1'($urandom);
            rst        = ($urandom_range(0, 1499) == 0);
            cycle();
        end
        rst = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
        repeat (300) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
